// File: rtl/nanorv32_trace_buffer.sv
// Retirement-trace collector for the nanorv32 core: captures retired instructions
// in program order, completes load/store records at the end of their AHB data phase.
module nanorv32_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ret_valid,
    input  logic [31:0]      ret_pc,
    input  logic [31:0]      ret_instr,
    input  logic             ret_wr_rd,
    input  logic [4:0]       ret_rd_idx,
    input  logic [31:0]      ret_rd_data,
    input  logic             htransd,
    input  logic             hwrited,
    input  logic             hreadyd,
    input  logic [31:0]      haddrd,
    input  logic [31:0]      hwdatad,
    input  logic [31:0]      hrdatad,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [1:0]       out_kind,
    output logic [4:0]       out_rd_idx,
    output logic [31:0]      out_data,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_cycle,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        KIND_ALU    = 2'b00,
        KIND_ALU_WR = 2'b01,
        KIND_LOAD   = 2'b10,
        KIND_STORE  = 2'b11
    } kind_e;

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      data_q  [DEPTH];
    logic [31:0]      addr_q  [DEPTH];
    logic [31:0]      cycle_q [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    kind_e            kind_q  [DEPTH];
    logic [DEPTH-1:0] done_q;

    logic [AW-1:0] head_q, tail_q, pend_slot_q;
    logic [AW:0]   count_q;
    logic          pend_q, pend_drop_q;
    logic [31:0]   cycle_cnt_q;

    logic        is_load, is_store, is_mem, pop, push, drop, complete;
    kind_e       kind_push;
    logic [4:0]  rd_push;
    logic [31:0] data_push, addr_push;

    // A stalled address phase (htransd & ~hreadyd) is never paired with a retirement, so it falls through to ALU.
    assign is_load  = ret_valid & htransd & hreadyd & ~hwrited;
    assign is_store = ret_valid & htransd & hreadyd & hwrited;
    assign is_mem   = is_load | is_store;
    assign pop      = out_valid & out_ready;
    assign push     = ret_valid & ((count_q < FULL_CNT) | pop);
    assign drop     = ret_valid & ~push;
    assign complete = pend_q & hreadyd;

    always_comb begin
        kind_push = KIND_ALU;
        if (is_load)        kind_push = KIND_LOAD;
        else if (is_store)  kind_push = KIND_STORE;
        else if (ret_wr_rd) kind_push = KIND_ALU_WR;
    end

    assign rd_push   = (kind_push == KIND_ALU_WR || kind_push == KIND_LOAD) ? ret_rd_idx : '0;
    assign data_push = is_mem ? '0 : ret_rd_data;
    assign addr_push = is_mem ? haddrd : '0;

    // Pending slot is always occupied and incomplete, so it never aliases the tail or a popping head.
    always_ff @(posedge clk) begin
        if (complete)
            data_q[pend_slot_q] <= (kind_q[pend_slot_q] == KIND_STORE) ? hwdatad : hrdatad;
        if (push) begin
            pc_q[tail_q]    <= ret_pc;
            instr_q[tail_q] <= ret_instr;
            kind_q[tail_q]  <= kind_push;
            rd_q[tail_q]    <= rd_push;
            data_q[tail_q]  <= data_push;
            addr_q[tail_q]  <= addr_push;
            cycle_q[tail_q] <= cycle_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_drop_q <= 1'b0;
            pend_slot_q <= '0;
            cycle_cnt_q <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (complete)
                done_q[pend_slot_q] <= 1'b1;
            if (push) begin
                done_q[tail_q] <= ~is_mem;
                tail_q         <= tail_q + 1'b1;
            end
            if (pop)
                head_q <= head_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (!push && pop)
                count_q <= count_q - 1'b1;

            // Any mem retirement coincides with hreadyd=1, which also closes the previous data phase.
            if (is_mem && push) begin
                pend_q      <= 1'b1;
                pend_drop_q <= 1'b0;
                pend_slot_q <= tail_q;
            end else if (is_mem && drop) begin
                pend_q      <= 1'b0;
                pend_drop_q <= 1'b1;
            end else if (hreadyd) begin
                pend_q      <= 1'b0;
                pend_drop_q <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1)
                    drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign out_valid  = (count_q != '0) && done_q[head_q];
    assign out_pc     = out_valid ? pc_q[head_q]    : '0;
    assign out_instr  = out_valid ? instr_q[head_q] : '0;
    assign out_kind   = out_valid ? kind_q[head_q]  : '0;
    assign out_rd_idx = out_valid ? rd_q[head_q]    : '0;
    assign out_data   = out_valid ? data_q[head_q]  : '0;
    assign out_addr   = out_valid ? addr_q[head_q]  : '0;
    assign out_cycle  = out_valid ? cycle_q[head_q] : '0;

endmodule

// File: tb/tb_nanorv32_trace_buffer.sv
// Scoreboard bench for nanorv32_trace_buffer: stimulus queues hand-built records,
// a negedge monitor pops and compares every accepted output record.
module tb_nanorv32_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] cyc;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ret_valid, ret_wr_rd;
    logic [31:0]      ret_pc, ret_instr, ret_rd_data;
    logic [4:0]       ret_rd_idx;
    logic             htransd, hwrited, hreadyd;
    logic [31:0]      haddrd, hwdatad, hrdatad;
    logic             out_valid, out_ready;
    logic [31:0]      out_pc, out_instr, out_data, out_addr, out_cycle;
    logic [1:0]       out_kind;
    logic [4:0]       out_rd_idx;
    logic             overflow;
    logic [CNT_W-1:0] drop_count;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc;
    rec_t        exp_q[$];

    always #5 clk = ~clk;

    nanorv32_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
        .ret_wr_rd(ret_wr_rd), .ret_rd_idx(ret_rd_idx), .ret_rd_data(ret_rd_data),
        .htransd(htransd), .hwrited(hwrited), .hreadyd(hreadyd),
        .haddrd(haddrd), .hwdatad(hwdatad), .hrdatad(hrdatad),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_kind(out_kind),
        .out_rd_idx(out_rd_idx), .out_data(out_data), .out_addr(out_addr),
        .out_cycle(out_cycle), .overflow(overflow), .drop_count(drop_count)
    );

    // Expected cycle stamp: number of clock edges seen with reset released.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    initial begin : monitor
        rec_t e, got;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                got = '{out_pc, out_instr, out_kind, out_rd_idx, out_data, out_addr, out_cycle};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_record got=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL record_pc_%h got=%h required=%h", e.pc, got, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ret_alu(input logic [31:0] pc, input logic [31:0] instr, input logic wr,
                           input logic [4:0] rd, input logic [31:0] data, input bit expect_it);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_wr_rd = wr;
        ret_rd_idx = rd; ret_rd_data = data; htransd = 1'b0;
        if (expect_it)
            exp_q.push_back('{pc, instr, wr ? 2'b01 : 2'b00, wr ? rd : 5'd0, data, 32'd0, cyc});
        tick();
        ret_valid = 1'b0;
    endtask

    task automatic ret_mem(input logic [31:0] pc, input logic [31:0] instr, input logic st,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data,
                           input bit expect_it);
        ret_valid = 1'b1; ret_pc = pc; ret_instr = instr; ret_wr_rd = ~st;
        ret_rd_idx = rd; ret_rd_data = 32'hFFFF_FFFF;
        htransd = 1'b1; hwrited = st; hreadyd = 1'b1; haddrd = addr;
        if (expect_it)
            exp_q.push_back('{pc, instr, st ? 2'b11 : 2'b10, st ? 5'd0 : rd, data, addr, cyc});
        tick();
        ret_valid = 1'b0; htransd = 1'b0; hwrited = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got=%0d_left required=0_left", name, exp_q.size());
        end
        tick();
        check({name, "_idle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; ret_wr_rd = 1'b0;
        ret_rd_idx = '0; ret_rd_data = '0; htransd = 1'b0; hwrited = 1'b0; hreadyd = 1'b1;
        haddrd = '0; hwdatad = '0; hrdatad = '0; out_ready = 1'b0;

        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_cycle", 64'(out_cycle), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        #10 rst_n = 1'b1;
        tick();

        // ALU stream with a trailing no-write retirement
        out_ready = 1'b1;
        ret_alu(32'h100, 32'h00A00513, 1'b1, 5'd10, 32'hCAFFE000, 1'b1);
        check("alu_latency", 64'(out_valid), 64'd1);
        ret_alu(32'h104, 32'h00A00513, 1'b1, 5'd10, 32'hCAFFE000, 1'b1);
        ret_alu(32'h108, 32'h00A00513, 1'b1, 5'd10, 32'hCAFFE000, 1'b1);
        ret_alu(32'h10C, 32'h00000013, 1'b0, 5'd10, 32'h00000077, 1'b1);
        drain("alu");

        // Load with two wait states, ALU retirements queued behind it
        ret_mem(32'h200, 32'h00052503, 1'b0, 5'd10, 32'h20000010, 32'hDEADD000, 1'b1);
        hreadyd = 1'b0;
        ret_alu(32'h204, 32'h00150513, 1'b1, 5'd10, 32'h00000011, 1'b1);
        check("load_wait1_valid", 64'(out_valid), 64'd0);
        ret_alu(32'h208, 32'h00250593, 1'b1, 5'd11, 32'h00000022, 1'b1);
        check("load_wait2_valid", 64'(out_valid), 64'd0);
        hreadyd = 1'b1; hrdatad = 32'hDEADD000;
        tick();
        hrdatad = '0;
        drain("load");

        // Store then load back-to-back: store data phase overlaps load address phase
        ret_mem(32'h300, 32'h00B52023, 1'b1, 5'd3, 32'h20000000, 32'h12345678, 1'b1);
        hwdatad = 32'h12345678;
        ret_mem(32'h304, 32'h00452583, 1'b0, 5'd11, 32'h20000004, 32'h0000ABCD, 1'b1);
        hwdatad = '0; hrdatad = 32'h0000ABCD;
        tick();
        hrdatad = '0;
        drain("b2b");

        // Backpressure: DEPTH+2 retirements, last two dropped
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++)
            ret_alu(32'h600 + 32'(4 * i), 32'h00000013, 1'b1, 5'd5, 32'h1000 + 32'(i), i < DEPTH);
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_drop_count", 64'(drop_count), 64'd2);
        check("bp_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain("bp");

        // Full FIFO, retirement in the same cycle as a pop is accepted
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ret_alu(32'h700 + 32'(4 * i), 32'h00000013, 1'b1, 5'd6, 32'h2000 + 32'(i), 1'b1);
        out_ready = 1'b1;
        ret_alu(32'h780, 32'h00000013, 1'b1, 5'd7, 32'h00002FFF, 1'b1);
        check("full_pop_drop_count", 64'(drop_count), 64'd2);
        drain("full_pop");

        // Reset during a load wait state
        ret_mem(32'h400, 32'h00052503, 1'b0, 5'd12, 32'h20000020, 32'h0, 1'b0);
        hreadyd = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_drop", 64'(drop_count), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_pc", 64'(out_pc), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        hreadyd = 1'b1; hrdatad = 32'hBAD0BAD0;
        tick();
        hrdatad = '0;
        ret_alu(32'h500, 32'h00100093, 1'b1, 5'd1, 32'h00000001, 1'b1);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
